// File: rtl/uart_rx_fifo_if.sv
// CPU-side read port of the UART receiver: FIFO head, occupancy and status.
// Master is the bus side that pops bytes; slave is the receiver.
interface uart_rx_fifo_if #(
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  rd_en;
  logic                  ovr_clr;
  logic [7:0]            rd_data;
  logic                  rd_valid;
  logic [DEPTH_LOG2:0]   count;
  logic                  frame_err;
  logic                  overrun;

  modport master (
    output rd_en, ovr_clr,
    input  rd_data, rd_valid, count, frame_err, overrun
  );

  modport slave (
    input  rd_en, ovr_clr,
    output rd_data, rd_valid, count, frame_err, overrun
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a show-ahead circular FIFO.
// Bytes with a bad stop bit are dropped and flagged via frame_err.
module uart_rx_fifo #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic          clk,
  input  logic          reset_async,
  input  logic          rs232_dce_rxd,
  uart_rx_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [15:0] HALF_CNT = 16'(CLK_DIV / 2 - 1);
  localparam logic [15:0] BIT_CNT  = 16'(CLK_DIV - 1);
  localparam logic [DEPTH_LOG2:0] CNT_FULL =
    {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_e;

  state_e state_q, state_d;
  logic   sync_q, rxd_s_q;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        push_q, push_d;
  logic        frame_err_q, frame_err_d;

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  overrun_q, overrun_d;
  logic [7:0]            mem_q [DEPTH];

  logic full, empty, pop, do_push, drop;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!rxd_s_q) begin
          state_d = S_START;
          cnt_d   = HALF_CNT;
        end
      end
      S_START: begin
        if (cnt_q == 16'd0) begin
          if (rxd_s_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            cnt_d   = BIT_CNT;
            bit_d   = 3'd0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_DATA: begin
        if (cnt_q == 16'd0) begin
          shreg_d = {rxd_s_q, shreg_q[7:1]};
          cnt_d   = BIT_CNT;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_STOP: begin
        if (cnt_q == 16'd0) begin
          if (rxd_s_q) begin
            push_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      S_BREAK: begin
        if (rxd_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A pop on an empty FIFO is ignored, so a full FIFO only accepts a push
  // when a real pop frees the slot in the same cycle.
  always_comb begin
    full      = (count_q == CNT_FULL);
    empty     = (count_q == '0);
    pop       = bus.rd_en && !empty;
    do_push   = push_q && (!full || pop);
    drop      = push_q && full && !pop;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (do_push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    unique case ({do_push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
    if (drop)             overrun_d = 1'b1;
    else if (bus.ovr_clr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset_async) begin
    if (reset_async) begin
      sync_q      <= 1'b1;
      rxd_s_q     <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= rs232_dce_rxd;
      rxd_s_q     <= sync_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shreg_q;
  end

  assign bus.rd_data   = mem_q[rd_ptr_q];
  assign bus.rd_valid  = !empty;
  assign bus.count     = count_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overrun   = overrun_q;
endmodule
